// File: rtl/secded_mem_ctrl.sv
// SECDED (Hamming 12,8 plus overall parity) memory controller with host port,
// single-error correction with writeback, and a background scrubber.
module secded_mem_ctrl #(
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [1:0]  rsp_err,
    input  logic        scrub_en,
    output logic        mem_we,
    output logic [3:0]  mem_addr,
    output logic [12:0] mem_wdata,
    input  logic [12:0] mem_rdata,
    output logic [7:0]  corr_count,
    output logic [7:0]  uncorr_count,
    output logic [3:0]  uncorr_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_WB
    } state_t;

    localparam logic [7:0] SCRUB_LAST = 8'(SCRUB_INTERVAL - 1);

    // Returns {p8, p4, p2, p1, overall} for one data byte.
    function automatic logic [4:0] f_check(input logic [7:0] d);
        logic p1, p2, p4, p8;
        p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
        p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
        return {p8, p4, p2, p1, (^d) ^ p1 ^ p2 ^ p4 ^ p8};
    endfunction

    // Codeword position of each data bit.
    function automatic logic [3:0] f_dpos(input int idx);
        case (idx)
            0:       return 4'd3;
            1:       return 4'd5;
            2:       return 4'd6;
            3:       return 4'd7;
            4:       return 4'd9;
            5:       return 4'd10;
            6:       return 4'd11;
            default: return 4'd12;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_addr;
    logic [7:0]  r_data;
    logic        r_src_scrub;
    logic [3:0]  r_scrub_ptr;
    logic [7:0]  r_scrub_timer;
    logic        r_scrub_pending;
    logic [7:0]  r_corr_count;
    logic [7:0]  r_uncorr_count;
    logic [3:0]  r_uncorr_addr;

    logic        w_accept;
    logic        w_scrub_start;
    logic [7:0]  w_rd_data;
    logic [4:0]  w_rd_chk;
    logic [4:0]  w_re_chk;
    logic [3:0]  w_synd;
    logic        w_par;
    logic        w_correctable;
    logic        w_uncorr;
    logic [7:0]  w_flip;
    logic [7:0]  w_corr_data;

    assign w_rd_data = mem_rdata[12:5];
    assign w_rd_chk  = mem_rdata[4:0];
    assign w_re_chk  = f_check(w_rd_data);
    assign w_synd    = w_re_chk[4:1] ^ w_rd_chk[4:1];
    assign w_par     = w_re_chk[0] ^ w_rd_chk[0];

    assign w_correctable = w_par && (w_synd <= 4'd12);
    assign w_uncorr      = (!w_par && (w_synd != 4'd0)) || (w_par && (w_synd >= 4'd13));

    // Syndromes pointing at parity positions leave the data untouched.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_flip
            assign w_flip[gi] = w_correctable && (w_synd == f_dpos(gi));
        end
    endgenerate

    assign w_corr_data = w_rd_data ^ w_flip;

    assign mem_addr     = r_addr;
    assign corr_count   = r_corr_count;
    assign uncorr_count = r_uncorr_count;
    assign uncorr_addr  = r_uncorr_addr;

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_scrub_start = 1'b0;
        req_ready     = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = 13'd0;
        rsp_valid     = 1'b0;
        rsp_rdata     = 8'd0;
        rsp_err       = 2'b00;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = req_write ? S_WRITE : S_READ;
                end else if (r_scrub_pending) begin
                    w_scrub_start = 1'b1;
                    w_state_next  = S_READ;
                end
            end
            S_WRITE: begin
                mem_we       = 1'b1;
                mem_wdata    = {r_data, f_check(r_data)};
                rsp_valid    = 1'b1;
                w_state_next = S_IDLE;
            end
            S_READ: begin
                w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!r_src_scrub) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = w_uncorr ? w_rd_data : w_corr_data;
                    rsp_err   = w_uncorr ? 2'b10 : (w_correctable ? 2'b01 : 2'b00);
                end
                w_state_next = w_correctable ? S_WB : S_IDLE;
            end
            S_WB: begin
                mem_we       = 1'b1;
                mem_wdata    = {r_data, f_check(r_data)};
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        // Reset aborts any in-flight operation without a memory write or response.
        if (reset) begin
            req_ready     = 1'b0;
            mem_we        = 1'b0;
            rsp_valid     = 1'b0;
            w_accept      = 1'b0;
            w_scrub_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_addr          <= 4'd0;
            r_data          <= 8'd0;
            r_src_scrub     <= 1'b0;
            r_scrub_ptr     <= 4'd0;
            r_scrub_timer   <= 8'd0;
            r_scrub_pending <= 1'b0;
            r_corr_count    <= 8'd0;
            r_uncorr_count  <= 8'd0;
            r_uncorr_addr   <= 4'd0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_addr      <= req_addr;
                r_data      <= req_wdata;
                r_src_scrub <= 1'b0;
            end
            if (w_scrub_start) begin
                r_addr      <= r_scrub_ptr;
                r_src_scrub <= 1'b1;
            end

            if (r_state == S_CHECK) begin
                if (w_correctable) begin
                    r_data <= w_corr_data;
                    if (r_corr_count != 8'hFF) r_corr_count <= r_corr_count + 8'd1;
                end
                if (w_uncorr) begin
                    r_uncorr_addr <= r_addr;
                    if (r_uncorr_count != 8'hFF) r_uncorr_count <= r_uncorr_count + 8'd1;
                end
                if (r_src_scrub) r_scrub_ptr <= r_scrub_ptr + 4'd1;
            end

            if (!scrub_en) begin
                r_scrub_timer   <= 8'd0;
                r_scrub_pending <= 1'b0;
            end else if (!r_scrub_pending) begin
                if (r_scrub_timer == SCRUB_LAST) begin
                    r_scrub_timer   <= 8'd0;
                    r_scrub_pending <= 1'b1;
                end else begin
                    r_scrub_timer <= r_scrub_timer + 8'd1;
                end
            end else if (w_scrub_start) begin
                r_scrub_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_secded_mem_ctrl.sv
// Directed bench for secded_mem_ctrl with a behavioural 16x13 memory that
// returns read data one cycle after the address.
module tb_secded_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_err;
    logic        scrub_en;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [12:0] mem_wdata;
    logic [12:0] mem_rdata;
    logic [7:0]  corr_count;
    logic [7:0]  uncorr_count;
    logic [3:0]  uncorr_addr;

    logic [12:0] mem [16];
    int          errors;
    int          checks;

    secded_mem_ctrl #(.SCRUB_INTERVAL(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .scrub_en     (scrub_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count),
        .uncorr_addr  (uncorr_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next scrub READ from IDLE and follows it back to IDLE.
    task automatic scrub_once(input logic [3:0] exp_addr);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ready === 1'b1 && n < 200);
        chk("scrub_started", req_ready, 1'b0);
        chk("scrub_addr", mem_addr, exp_addr);
        tick();
        chk("scrub_no_rsp", rsp_valid, 1'b0);
        n = 0;
        while (req_ready !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk("scrub_done", req_ready, 1'b1);
    endtask

    initial begin
        int busy;
        errors    = 0;
        checks    = 0;
        clk       = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'd0;
        req_wdata = 8'd0;
        scrub_en  = 1'b0;
        mem_rdata = 13'd0;
        for (int i = 0; i < 16; i++) mem[i] = 13'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", req_ready, 1'b1);
        chk("post_rst_corr", corr_count, 8'd0);
        chk("post_rst_uncorr", uncorr_count, 8'd0);
        chk("post_rst_uaddr", uncorr_addr, 4'd0);
        chk("post_rst_maddr", mem_addr, 4'd0);
        chk("post_rst_rsp", rsp_valid, 1'b0);

        // Write 0xA5 to address 3: codeword {A5, 00110} = 0x14A6.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
        tick();
        req_valid = 1'b0;
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, 4'd3);
        chk("wr_wdata", mem_wdata, 13'h14A6);
        chk("wr_rsp", rsp_valid, 1'b1);
        chk("wr_err", rsp_err, 2'b00);
        chk("wr_rdata", rsp_rdata, 8'd0);
        chk("wr_ready", req_ready, 1'b0);
        tick();
        chk("wr_idle_ready", req_ready, 1'b1);
        chk("wr_idle_we", mem_we, 1'b0);
        chk("wr_mem3", mem[3], 13'h14A6);

        // Clean read of address 3.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
        tick();
        req_valid = 1'b0;
        chk("rd_early_rsp", rsp_valid, 1'b0);
        chk("rd_addr", mem_addr, 4'd3);
        chk("rd_wdata_idle", mem_wdata, 13'd0);
        tick();
        chk("rd_rsp", rsp_valid, 1'b1);
        chk("rd_rdata", rsp_rdata, 8'hA5);
        chk("rd_err", rsp_err, 2'b00);
        tick();
        chk("rd_no_wb", mem_we, 1'b0);
        chk("rd_ready", req_ready, 1'b1);

        // Flip d0 (codeword position 3) of address 3, then read.
        mem[3] = mem[3] ^ 13'h020;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
        tick();
        req_valid = 1'b0;
        tick();
        chk("ce_rsp", rsp_valid, 1'b1);
        chk("ce_rdata", rsp_rdata, 8'hA5);
        chk("ce_err", rsp_err, 2'b01);
        tick();
        chk("ce_wb_we", mem_we, 1'b1);
        chk("ce_wb_addr", mem_addr, 4'd3);
        chk("ce_wb_wdata", mem_wdata, 13'h14A6);
        chk("ce_wb_rsp", rsp_valid, 1'b0);
        chk("ce_corr", corr_count, 8'd1);
        tick();
        chk("ce_mem3", mem[3], 13'h14A6);
        chk("ce_ready", req_ready, 1'b1);

        // Write 0x3C to address 5 (codeword 0x785), flip d0 and d1, then read.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 8'h3C;
        tick();
        req_valid = 1'b0;
        chk("wr5_wdata", mem_wdata, 13'h0785);
        tick();
        mem[5] = mem[5] ^ 13'h060;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
        tick();
        req_valid = 1'b0;
        tick();
        chk("ue_rsp", rsp_valid, 1'b1);
        chk("ue_rdata", rsp_rdata, 8'h3F);
        chk("ue_err", rsp_err, 2'b10);
        chk("ue_we", mem_we, 1'b0);
        tick();
        chk("ue_idle_we", mem_we, 1'b0);
        chk("ue_ready", req_ready, 1'b1);
        chk("ue_count", uncorr_count, 8'd1);
        chk("ue_uaddr", uncorr_addr, 4'd5);
        chk("ue_corr_held", corr_count, 8'd1);
        chk("ue_mem5", mem[5], 13'h07E5);

        // Reset arriving in the WB cycle drops the writeback.
        mem[3] = mem[3] ^ 13'h020;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("rwb_in_wb", mem_we, 1'b1);
        chk("rwb_corr2", corr_count, 8'd2);
        reset = 1'b1;
        #1;
        chk("rwb_we", mem_we, 1'b0);
        chk("rwb_rsp", rsp_valid, 1'b0);
        chk("rwb_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rwb_idle", req_ready, 1'b1);
        chk("rwb_corr", corr_count, 8'd0);
        chk("rwb_uncorr", uncorr_count, 8'd0);
        chk("rwb_uaddr", uncorr_addr, 4'd0);
        chk("rwb_mem3", mem[3], 13'h1486);

        // First scrub: pending after 64 enabled edges, READ of address 0 on the next.
        mem[0] = 13'h020;
        scrub_en = 1'b1;
        repeat (63) tick();
        chk("sc_wait_ready", req_ready, 1'b1);
        tick();
        chk("sc_pend_ready", req_ready, 1'b1);
        tick();
        chk("sc_read_ready", req_ready, 1'b0);
        chk("sc_read_addr", mem_addr, 4'd0);
        tick();
        chk("sc_no_rsp", rsp_valid, 1'b0);
        tick();
        chk("sc_wb_we", mem_we, 1'b1);
        chk("sc_wb_addr", mem_addr, 4'd0);
        chk("sc_wb_wdata", mem_wdata, 13'd0);
        chk("sc_corr", corr_count, 8'd1);
        tick();
        chk("sc_mem0", mem[0], 13'd0);
        chk("sc_ready", req_ready, 1'b1);

        // Host write lands on the edge where the second scrub becomes pending.
        repeat (60) tick();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7; req_wdata = 8'h0F;
        tick();
        req_valid = 1'b0;
        chk("col_we", mem_we, 1'b1);
        chk("col_addr", mem_addr, 4'd7);
        chk("col_wdata", mem_wdata, 13'h01EF);
        chk("col_rsp", rsp_valid, 1'b1);
        tick();
        chk("col_idle", req_ready, 1'b1);
        tick();
        chk("col_scrub_ready", req_ready, 1'b0);
        chk("col_scrub_addr", mem_addr, 4'd1);
        tick();
        chk("col_scrub_rsp", rsp_valid, 1'b0);
        tick();
        chk("col_back_idle", req_ready, 1'b1);

        for (int a = 2; a < 16; a++) scrub_once(4'(a));
        scrub_once(4'd0);
        chk("sweep_corr", corr_count, 8'd2);
        chk("sweep_uncorr", uncorr_count, 8'd1);
        chk("sweep_uaddr", uncorr_addr, 4'd5);
        chk("sweep_mem3", mem[3], 13'h14A6);
        chk("sweep_mem5", mem[5], 13'h07E5);

        // Disabled scrubber stays quiet.
        scrub_en = 1'b0;
        busy = 0;
        repeat (100) begin
            tick();
            if (req_ready !== 1'b1) busy++;
        end
        chk("scrub_off_quiet", 16'(busy), 16'd0);

        // Uncorrectable counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
            tick();
            req_valid = 1'b0;
            tick();
            tick();
        end
        chk("sat_uncorr", uncorr_count, 8'hFF);
        chk("sat_uaddr", uncorr_addr, 4'd5);
        chk("sat_corr", corr_count, 8'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/secded_mem_ctrl.md
SECDED_MEM_CTRL -- requirements
Module: secded_mem_ctrl

Interface
REQ-001 Parameter SCRUB_INTERVAL, default 64, idle cycles between background scrub reads (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  request accepted on a cycle where req_valid and req_ready are both 1.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  4  word address, 16 entries.
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle response pulse.
REQ-010 rsp_rdata  output  8  read data, corrected if needed; 0 for writes.
REQ-011 rsp_err  output  2  00 clean, 01 corrected single error, 10 uncorrectable.
REQ-012 scrub_en  input  1  enables background scrubbing.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  4  memory address.
REQ-015 mem_wdata  output  13  codeword {data[7:0], check[4:0]}.
REQ-016 mem_rdata  input  13  codeword read from mem_addr, valid the cycle after the address is driven with mem_we=0.
REQ-017 corr_count  output  8  corrected-error count, saturating at 255.
REQ-018 uncorr_count  output  8  uncorrectable-error count, saturating at 255.
REQ-019 uncorr_addr  output  4  address of the most recent uncorrectable error.

Function
REQ-020 Codeword positions 1..12: p1@1, p2@2, d0@3, p4@4, d1@5, d2@6, d3@7, p8@8, d4@9, d5@10, d6@11, d7@12.
REQ-021 The encoding SHALL be even Hamming parity, with check[1]=p1, check[2]=p2, check[3]=p4, check[4]=p8, and check[0] = XOR of d7..d0 and p8..p1.
REQ-022 Decode: recompute check from the read data; synd[3:0] = recomputed check[4:1] XOR stored check[4:1]; par = recomputed check[0] XOR stored check[0].
REQ-023 Decode SHALL classify as follows: par=0 and synd=0 is clean; par=1 and synd in 0..12 is correctable; par=0 and synd!=0 is uncorrectable; par=1 and synd in 13..15 is uncorrectable.
REQ-024 Correctable: synd 3..12 inverts the data bit at that position; synd 0,1,2,4,8 leaves the data unchanged; a writeback is always performed.
REQ-025 The FSM SHALL have the states IDLE, WRITE, READ, CHECK and WB.
REQ-026 req_ready SHALL be 1 only in IDLE with reset low.
REQ-027 In IDLE, an accepted write SHALL go to WRITE; an accepted read SHALL go to READ with source=host.
REQ-028 In IDLE with no req_valid and scrub_pending=1, the FSM SHALL go to READ with source=scrub, address=scrub_ptr, and clear scrub_pending.
REQ-029 Host requests SHALL take priority over scrub; scrub_pending stays set until served.
REQ-030 WRITE (1 cycle): mem_we=1, mem_addr=latched address, mem_wdata=encoded data; rsp_valid=1, rsp_err=00; next state IDLE.
REQ-031 READ (1 cycle): mem_we=0, mem_addr=latched address; next state CHECK.
REQ-032 CHECK (1 cycle): decode mem_rdata.
REQ-033 In CHECK with source=host: rsp_valid=1, rsp_rdata=corrected data, rsp_err per classification.
REQ-034 In CHECK, uncorrectable SHALL report rsp_rdata = raw stored data.
REQ-035 In CHECK, correctable SHALL go to WB and increment corr_count; all other cases SHALL go to IDLE.
REQ-036 In CHECK, uncorrectable SHALL increment uncorr_count and load uncorr_addr; no writeback.
REQ-037 WB (1 cycle): mem_we=1, mem_addr=latched address, mem_wdata=fresh encoding of the corrected data; next state IDLE.
REQ-038 Scrub reads SHALL never assert rsp_valid.
REQ-039 scrub_ptr SHALL increment in CHECK when source=scrub, wrapping 15 -> 0.
REQ-040 Scrub timer (8-bit) SHALL count every cycle while scrub_en=1 and scrub_pending=0.
REQ-041 At SCRUB_INTERVAL-1 the scrub timer SHALL reset to 0 and set scrub_pending.
REQ-042 When scrub_en=0, the scrub timer and scrub_pending SHALL be cleared; an in-flight scrub completes.
REQ-043 Host latency: write response 1 cycle after accept; read response 2 cycles after accept; next accept 2 cycles (write), 3 cycles (clean read) or 4 cycles (corrected read) after accept.
REQ-044 Counters SHALL hold at 255; an increment while at 255 has no effect.
REQ-045 When not in WRITE, CHECK or WB, outputs SHALL be idle: mem_we=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=00; mem_addr SHALL hold the latched address.

Reset
REQ-046 On a clock edge with reset=1: state=IDLE; scrub_ptr, scrub timer, scrub_pending, latched address, corr_count, uncorr_count and uncorr_addr SHALL all be 0.
REQ-047 While reset=1, mem_we, rsp_valid and req_ready SHALL be 0 combinationally, including mid-WRITE or mid-WB; the aborted operation is dropped with no response.

Verification
REQ-048 Write addr 3 data 0xA5, then read addr 3 -> rsp_valid 2 cycles after the read accept, rsp_rdata=0xA5, rsp_err=00, no WB.
REQ-049 Flip stored d0 (codeword position 3) of addr 3 in the memory model, then read -> rsp_rdata=0xA5, rsp_err=01, WB next cycle rewrites the original codeword, corr_count=1.
REQ-050 Flip d0 and d1 of addr 5, then read -> rsp_err=10, no mem_we, uncorr_count=1, uncorr_addr=5.
REQ-051 scrub_en=1, no host traffic, SCRUB_INTERVAL=64 -> scrub read of addr 0 starts 64 cycles after enable; a single-bit error there is written back; after 16 scrubs scrub_ptr wraps to 0.
REQ-052 req_valid asserted on the same cycle scrub_pending sets -> host served first, scrub READ begins immediately after the host transaction ends.
REQ-053 reset asserted during WB -> mem_we=0 that cycle, IDLE next cycle, all counters 0.
